// File: rtl/svmrow_acc_multi.sv
// Multi-lane linear-SVM row evaluator: NCH windows share one streamed coefficient
// vector; each lane accumulates a saturated dot product, then biases and thresholds it.
module svmrow_acc_multi #(
  parameter int DWIDTH  = 8,
  parameter int CWIDTH  = 9,
  parameter int NCH     = 8,
  parameter int FEATLEN = 2048,
  parameter int AWIDTH  = 24,
  localparam int FCW    = (FEATLEN > 1) ? $clog2(FEATLEN) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sof,
  input  logic                     dvi_in,
  input  logic [NCH*DWIDTH-1:0]    data,
  input  logic signed [CWIDTH-1:0] svcoeff_in,
  input  logic signed [AWIDTH-1:0] bias,
  input  logic signed [AWIDTH-1:0] threshold,
  output logic [FCW-1:0]           featcount,
  output logic [NCH-1:0]           svmres,
  output logic [NCH*AWIDTH-1:0]    score,
  output logic [NCH-1:0]           ovf,
  output logic                     dvo
);

  localparam int PW = DWIDTH + CWIDTH + 1;
  localparam logic [FCW-1:0] LAST_IDX = FCW'(FEATLEN - 1);
  localparam logic signed [AWIDTH-1:0] ACC_MAX = {1'b0, {(AWIDTH-1){1'b1}}};
  localparam logic signed [AWIDTH-1:0] ACC_MIN = {1'b1, {(AWIDTH-1){1'b0}}};

  // Returns {saturated, clamped_sum}; overflow shows as disagreement of the top two bits.
  function automatic logic [AWIDTH:0] sat_add(input logic signed [AWIDTH-1:0] a,
                                              input logic signed [AWIDTH-1:0] b);
    logic signed [AWIDTH:0] s;
    s = {a[AWIDTH-1], a} + {b[AWIDTH-1], b};
    if (s[AWIDTH] != s[AWIDTH-1])
      sat_add = {1'b1, (s[AWIDTH] ? ACC_MIN : ACC_MAX)};
    else
      sat_add = {1'b0, s[AWIDTH-1:0]};
  endfunction

  logic [FCW-1:0] featcount_q, featcount_d;
  logic [FCW-1:0] beat_idx;
  logic           beat_first, beat_last;

  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_first_q, s1_first_d;
  logic                 s1_last_q, s1_last_d;
  logic signed [PW-1:0] prod_q [NCH];
  logic signed [PW-1:0] prod_d [NCH];

  logic signed [AWIDTH-1:0] acc_q [NCH];
  logic signed [AWIDTH-1:0] acc_d [NCH];
  logic signed [AWIDTH-1:0] prod_ext [NCH];
  logic [AWIDTH:0]          acc_res [NCH];
  logic [NCH-1:0]           acc_ovf_q, acc_ovf_d;
  logic                     s2_last_q, s2_last_d;

  logic [AWIDTH:0]       fin_res [NCH];
  logic [NCH*AWIDTH-1:0] score_q, score_d;
  logic [NCH-1:0]        svmres_q, svmres_d;
  logic [NCH-1:0]        ovf_q, ovf_d;
  logic                  dvo_q, dvo_d;

  // sof forces index 0 so a sof beat can never also be tagged last
  always_comb begin
    beat_idx    = sof ? '0 : featcount_q;
    beat_first  = (beat_idx == '0);
    beat_last   = (beat_idx == LAST_IDX);
    featcount_d = featcount_q;
    if (dvi_in)
      featcount_d = (beat_idx == LAST_IDX) ? '0 : beat_idx + FCW'(1);
    else if (sof)
      featcount_d = '0;
  end

  always_comb begin
    s1_valid_d = dvi_in;
    s1_first_d = s1_first_q;
    s1_last_d  = s1_last_q;
    for (int i = 0; i < NCH; i++)
      prod_d[i] = prod_q[i];
    if (dvi_in) begin
      s1_first_d = beat_first;
      s1_last_d  = beat_last;
      for (int i = 0; i < NCH; i++)
        prod_d[i] = PW'($signed({1'b0, data[i*DWIDTH +: DWIDTH]})) * PW'(svcoeff_in);
    end
  end

  // A first beat loads over whatever is in the accumulator, so abandoned vectors never leak
  always_comb begin
    s2_last_d = s1_valid_q & s1_last_q;
    acc_ovf_d = acc_ovf_q;
    for (int i = 0; i < NCH; i++) begin
      prod_ext[i] = AWIDTH'(prod_q[i]);
      acc_res[i]  = sat_add(s1_first_q ? '0 : acc_q[i], prod_ext[i]);
      acc_d[i]    = acc_q[i];
      if (s1_valid_q) begin
        acc_d[i]     = acc_res[i][AWIDTH-1:0];
        acc_ovf_d[i] = acc_res[i][AWIDTH] | (acc_ovf_q[i] & ~s1_first_q);
      end
    end
  end

  always_comb begin
    score_d  = score_q;
    svmres_d = svmres_q;
    ovf_d    = ovf_q;
    dvo_d    = 1'b0;
    for (int i = 0; i < NCH; i++)
      fin_res[i] = sat_add(acc_q[i], bias);
    if (s2_last_q) begin
      dvo_d = 1'b1;
      for (int i = 0; i < NCH; i++) begin
        score_d[i*AWIDTH +: AWIDTH] = fin_res[i][AWIDTH-1:0];
        svmres_d[i] = $signed(fin_res[i][AWIDTH-1:0]) > threshold;
        ovf_d[i]    = acc_ovf_q[i] | fin_res[i][AWIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      featcount_q <= '0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_last_q   <= 1'b0;
      acc_ovf_q   <= '0;
      score_q     <= '0;
      svmres_q    <= '0;
      ovf_q       <= '0;
      dvo_q       <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        prod_q[i] <= '0;
        acc_q[i]  <= '0;
      end
    end else begin
      featcount_q <= featcount_d;
      s1_valid_q  <= s1_valid_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s2_last_q   <= s2_last_d;
      acc_ovf_q   <= acc_ovf_d;
      score_q     <= score_d;
      svmres_q    <= svmres_d;
      ovf_q       <= ovf_d;
      dvo_q       <= dvo_d;
      for (int i = 0; i < NCH; i++) begin
        prod_q[i] <= prod_d[i];
        acc_q[i]  <= acc_d[i];
      end
    end
  end

  assign featcount = featcount_q;
  assign svmres    = svmres_q;
  assign score     = score_q;
  assign ovf       = ovf_q;
  assign dvo       = dvo_q;

endmodule

// File: tb/tb_svmrow_acc_multi.sv
// Scoreboard bench for svmrow_acc_multi: a behavioural model predicts each vector result
// when its last beat is driven; results are checked (with latency) as dvo pulses arrive.
module tb_svmrow_acc_multi;

  localparam int AW  = 18;
  localparam int FL  = 4;
  localparam int AW2 = 24;
  localparam longint AMAX = (longint'(1) << (AW - 1)) - 1;
  localparam longint AMIN = -(longint'(1) << (AW - 1));

  typedef struct {
    logic [2*AW-1:0] score;
    logic [1:0]      svm;
    logic [1:0]      ovf;
    int              cyc;
  } exp_t;

  logic                 clk;
  logic                 reset_n;
  logic                 sof, dvi_in;
  logic [15:0]          data;
  logic signed [8:0]    svcoeff_in;
  logic signed [AW-1:0] bias, threshold;
  logic [1:0]           featcount;
  logic [1:0]           svmres;
  logic [2*AW-1:0]      score;
  logic [1:0]           ovf;
  logic                 dvo;

  logic                  sof2, dvi2;
  logic [7:0]            data2;
  logic signed [8:0]     coeff2;
  logic signed [AW2-1:0] bias2, threshold2;
  logic [1:0]            featcount2;
  logic [0:0]            svmres2;
  logic [AW2-1:0]        score2;
  logic [0:0]            ovf2;
  logic                  dvo2;

  exp_t   sb[$];
  int     checks = 0;
  int     passes = 0;
  int     cyc = 0;
  int     m_idx = 0;
  longint m_acc[2];
  bit     m_ovf[2];

  svmrow_acc_multi #(.DWIDTH(8), .CWIDTH(9), .NCH(2), .FEATLEN(FL), .AWIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n), .sof(sof), .dvi_in(dvi_in), .data(data),
    .svcoeff_in(svcoeff_in), .bias(bias), .threshold(threshold), .featcount(featcount),
    .svmres(svmres), .score(score), .ovf(ovf), .dvo(dvo));

  svmrow_acc_multi #(.DWIDTH(8), .CWIDTH(9), .NCH(1), .FEATLEN(3), .AWIDTH(AW2)) dut2 (
    .clk(clk), .reset_n(reset_n), .sof(sof2), .dvi_in(dvi2), .data(data2),
    .svcoeff_in(coeff2), .bias(bias2), .threshold(threshold2), .featcount(featcount2),
    .svmres(svmres2), .score(score2), .ovf(ovf2), .dvo(dvo2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint clamp(input longint v, inout bit o);
    if (v > AMAX) begin
      o = 1'b1;
      return AMAX;
    end
    if (v < AMIN) begin
      o = 1'b1;
      return AMIN;
    end
    return v;
  endfunction

  // Advance one clock; the scoreboard consumer pops and checks on every dvo pulse.
  task automatic step();
    exp_t e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (dvo === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        $display("[TB] FAIL unexpected_dvo: dvo=1 at cyc %0d, required no pulse", cyc);
      end else begin
        e = sb.pop_front();
        if (score !== e.score || svmres !== e.svm || ovf !== e.ovf || cyc != e.cyc)
          $display("[TB] FAIL dvo_result: score=%h svmres=%b ovf=%b cyc=%0d, required score=%h svmres=%b ovf=%b cyc=%0d",
                   score, svmres, ovf, cyc, e.score, e.svm, e.ovf, e.cyc);
        else
          passes++;
      end
    end
  endtask

  // Drive one cycle of stimulus, checking featcount first and updating the model.
  task automatic drive(input bit s, input bit v, input int d0, input int d1, input int c);
    int     idx;
    int     d[2];
    longint sc;
    bit     so;
    exp_t   e;
    logic [1:0] fc_exp;
    fc_exp = m_idx[1:0];
    checks++;
    if (featcount !== fc_exp)
      $display("[TB] FAIL featcount: got %0d, required %0d", featcount, fc_exp);
    else
      passes++;
    sof        = s;
    dvi_in     = v;
    data       = {d1[7:0], d0[7:0]};
    svcoeff_in = c[8:0];
    d[0] = d0;
    d[1] = d1;
    if (v) begin
      idx = s ? 0 : m_idx;
      for (int l = 0; l < 2; l++) begin
        if (idx == 0) begin
          m_ovf[l] = 1'b0;
          m_acc[l] = clamp(longint'(d[l]) * longint'(c), m_ovf[l]);
        end else begin
          m_acc[l] = clamp(m_acc[l] + longint'(d[l]) * longint'(c), m_ovf[l]);
        end
      end
      if (idx == FL - 1) begin
        for (int l = 0; l < 2; l++) begin
          so = m_ovf[l];
          sc = clamp(m_acc[l] + longint'(bias), so);
          e.score[l*AW +: AW] = sc[AW-1:0];
          e.svm[l] = (sc > longint'(threshold));
          e.ovf[l] = so;
        end
        e.cyc = cyc + 3;
        sb.push_back(e);
      end
      m_idx = (idx == FL - 1) ? 0 : idx + 1;
    end else if (s) begin
      m_idx = 0;
    end
    step();
  endtask

  task automatic idle(input int n);
    sof    = 1'b0;
    dvi_in = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && sb.size() > 0; i++) idle(1);
    idle(2);
    checks++;
    if (sb.size() != 0) begin
      $display("[TB] FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end else begin
      passes++;
    end
  endtask

  task automatic send_vec(input int d0, input int d1, input int c0, input int c1,
                          input int c2, input int c3, input int gap);
    int cs[4];
    cs = '{c0, c1, c2, c3};
    for (int b = 0; b < 4; b++) begin
      drive(b == 0, 1'b1, d0, d1, cs[b]);
      for (int g = 0; g < gap && b < 3; g++) drive(1'b0, 1'b0, 0, 0, 0);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({featcount, svmres, score, ovf, dvo} !== '0)
      $display("[TB] FAIL reset_state: fc=%0d svm=%b score=%h ovf=%b dvo=%b, required all 0",
               featcount, svmres, score, ovf, dvo);
    else
      passes++;
  endtask

  task automatic test_basic();
    bias = 0; threshold = 0;
    send_vec(1, 2, 3, -1, 2, 5, 0);
    drain();
    bias = -10;
    send_vec(1, 2, 3, -1, 2, 5, 0);
    drain();
  endtask

  task automatic test_stalls();
    bias = 0; threshold = 0;
    send_vec(1, 2, 3, -1, 2, 5, 2);
    drain();
  endtask

  task automatic test_back_to_back();
    bias = 7; threshold = 0;
    send_vec(1, 2, 3, -1, 2, 5, 0);
    send_vec(9, 4, 0, 0, 0, 0, 0);
    drain();
  endtask

  task automatic test_saturation();
    bias = 0; threshold = 0;
    send_vec(255, 1, 255, 255, 255, 255, 0);
    drain();
    send_vec(255, 255, -256, -256, -256, -256, 0);
    drain();
    send_vec(1, 2, 3, -1, 2, 5, 0);
    drain();
    bias = 70000;
    send_vec(255, 1, 255, 0, 0, 0, 0);
    drain();
  endtask

  task automatic test_sof_abort();
    bias = 3; threshold = 20;
    drive(1'b1, 1'b1, 50, 60, 100);
    drive(1'b0, 1'b1, 50, 60, 100);
    send_vec(4, 5, 1, 2, 3, 4, 0);
    drain();
    drive(1'b1, 1'b1, 7, 7, 7);
    drive(1'b0, 1'b1, 7, 7, 7);
    drive(1'b1, 1'b0, 0, 0, 0);
    send_vec(2, 3, 1, 1, 1, 1, 0);
    drain();
    drive(1'b1, 1'b1, 9, 9, 9);
    drive(1'b0, 1'b1, 9, 9, 9);
    drive(1'b0, 1'b1, 9, 9, 9);
    drive(1'b1, 1'b1, 6, 1, 2);
    drive(1'b0, 1'b1, 6, 1, -3);
    drive(1'b0, 1'b1, 6, 1, 4);
    drive(1'b0, 1'b1, 6, 1, 5);
    drain();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 33, 44, 55);
    drive(1'b0, 1'b1, 33, 44, 55);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({featcount, svmres, score, ovf, dvo} !== '0)
      $display("[TB] FAIL reset_mid_outputs: fc=%0d svm=%b score=%h ovf=%b dvo=%b, required all 0",
               featcount, svmres, score, ovf, dvo);
    else
      passes++;
    m_idx = 0;
    step();
    reset_n = 1'b1;
    idle(6);
    bias = 0; threshold = 0;
    send_vec(1, 2, 3, -1, 2, 5, 0);
    drain();
  endtask

  task automatic test_odd_featlen();
    int pulses;
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (featcount2 !== 2'(k)) $display("[TB] FAIL featcount_odd: got %0d, required %0d", featcount2, k);
      else passes++;
      dvi2 = 1'b1; data2 = 8'd10; coeff2 = 9'(k + 1);
      step();
      if (dvo2 === 1'b1) pulses++;
    end
    dvi2 = 1'b0;
    checks++;
    if (featcount2 !== 2'd0) $display("[TB] FAIL featcount_wrap: got %0d, required 0", featcount2);
    else passes++;
    for (int w = 0; w < 8; w++) begin
      step();
      if (dvo2 === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1 || score2 !== 24'd60 || svmres2 !== 1'b1 || ovf2 !== 1'b0)
      $display("[TB] FAIL odd_result: pulses=%0d score=%0d svm=%b ovf=%b, required 1/60/1/0",
               pulses, score2, svmres2, ovf2);
    else
      passes++;
    dvi2 = 1'b1;
    step();
    step();
    dvi2 = 1'b0;
    checks++;
    if (featcount2 !== 2'd2) $display("[TB] FAIL featcount_odd2: got %0d, required 2", featcount2);
    else passes++;
    dvi2 = 1'b1;
    step();
    dvi2 = 1'b0;
    checks++;
    if (featcount2 !== 2'd0) $display("[TB] FAIL featcount_wrap2: got %0d, required 0", featcount2);
    else passes++;
    idle(5);
  endtask

  initial begin
    reset_n = 1'b0;
    sof = 1'b0; dvi_in = 1'b0; data = '0; svcoeff_in = '0; bias = '0; threshold = '0;
    sof2 = 1'b0; dvi2 = 1'b0; data2 = '0; coeff2 = '0; bias2 = '0; threshold2 = 24'sd50;
    repeat (2) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    idle(2);
    test_basic();
    test_stalls();
    test_back_to_back();
    test_saturation();
    test_sof_abort();
    test_reset_mid();
    test_odd_featlen();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
